// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: decode->execute pipeline register with stall/flush control and saturating event counters
module id_ex_pipeline_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_E,
    input  logic             flush_E,
    input  logic             valid_D,
    input  logic [15:0]      ctrl_D,
    input  logic [XLEN-1:0]  rd1_D,
    input  logic [XLEN-1:0]  rd2_D,
    input  logic [XLEN-1:0]  imm_ext_D,
    input  logic [XLEN-1:0]  pc_D,
    input  logic [XLEN-1:0]  pcp4_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    input  logic [2:0]       funct3_D,
    input  logic             funct7b5_D,
    output logic [15:0]      ctrl_E,
    output logic [XLEN-1:0]  rd1_E,
    output logic [XLEN-1:0]  rd2_E,
    output logic [XLEN-1:0]  imm_ext_E,
    output logic [XLEN-1:0]  pc_E,
    output logic [XLEN-1:0]  pcp4_E,
    output logic [4:0]       rs1_E,
    output logic [4:0]       rs2_E,
    output logic [4:0]       rd_E,
    output logic [2:0]       funct3_E,
    output logic             funct7b5_E,
    output logic             valid_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic [15:0]      ctrl_d, ctrl_q;
    logic [XLEN-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_ext_d, imm_ext_q;
    logic [XLEN-1:0]  pc_d, pc_q, pcp4_d, pcp4_q;
    logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [2:0]       funct3_d, funct3_q;
    logic             funct7b5_d, funct7b5_q, valid_d, valid_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
    always_comb begin
        ctrl_d      = flush_E ? '0   : stall_E ? ctrl_q     : ctrl_D;
        rd1_d       = flush_E ? '0   : stall_E ? rd1_q      : rd1_D;
        rd2_d       = flush_E ? '0   : stall_E ? rd2_q      : rd2_D;
        imm_ext_d   = flush_E ? '0   : stall_E ? imm_ext_q  : imm_ext_D;
        pc_d        = flush_E ? '0   : stall_E ? pc_q       : pc_D;
        pcp4_d      = flush_E ? '0   : stall_E ? pcp4_q     : pcp4_D;
        rs1_d       = flush_E ? '0   : stall_E ? rs1_q      : rs1_D;
        rs2_d       = flush_E ? '0   : stall_E ? rs2_q      : rs2_D;
        rd_d        = flush_E ? '0   : stall_E ? rd_q       : rd_D;
        funct3_d    = flush_E ? '0   : stall_E ? funct3_q   : funct3_D;
        funct7b5_d  = flush_E ? 1'b0 : stall_E ? funct7b5_q : funct7b5_D;
        valid_d     = flush_E ? 1'b0 : stall_E ? valid_q    : valid_D;
        stall_cnt_d = (stall_E && !flush_E && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_E && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_ext_q   <= '0;
            pc_q        <= '0;
            pcp4_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_ext_q   <= imm_ext_d;
            pc_q        <= pc_d;
            pcp4_q      <= pcp4_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign ctrl_E     = ctrl_q;
    assign rd1_E      = rd1_q;
    assign rd2_E      = rd2_q;
    assign imm_ext_E  = imm_ext_q;
    assign pc_E       = pc_q;
    assign pcp4_E     = pcp4_q;
    assign rs1_E      = rs1_q;
    assign rs2_E      = rs2_q;
    assign rd_E       = rd_q;
    assign funct3_E   = funct3_q;
    assign funct7b5_E = funct7b5_q;
    assign valid_E    = valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: vector table, corner sequences and random traffic checked against a stage model
module tb_id_ex_pipeline_reg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    typedef struct packed {
        logic [15:0]     ctrl;
        logic [XLEN-1:0] rd1, rd2, imm, pc, pcp4;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
        logic            valid;
    } e_t;
    typedef struct {
        logic        rst, flush, stall, valid;
        logic [15:0] ctrl;
        logic [31:0] rd1;
        logic [4:0]  rd;
        logic        x_valid;
        logic [15:0] x_ctrl;
        logic [31:0] x_rd1;
        logic [4:0]  x_rd;
        int          x_sc, x_fc;
    } vec_t;
    logic clk = 1'b0;
    logic rst, stall_E, flush_E, valid_D, funct7b5_D;
    logic [15:0] ctrl_D;
    logic [XLEN-1:0] rd1_D, rd2_D, imm_ext_D, pc_D, pcp4_D;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic [2:0] funct3_D;
    logic [15:0] ctrl_E;
    logic [XLEN-1:0] rd1_E, rd2_E, imm_ext_E, pc_E, pcp4_E;
    logic [4:0] rs1_E, rs2_E, rd_E;
    logic [2:0] funct3_E;
    logic funct7b5_E, valid_E;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int tests = 0, fails = 0;
    e_t exp_e, dut_e;
    int sc, fc;
    vec_t vt[14];

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
        .ctrl_D(ctrl_D), .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_ext_D(imm_ext_D), .pc_D(pc_D),
        .pcp4_D(pcp4_D), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .funct3_D(funct3_D),
        .funct7b5_D(funct7b5_D), .ctrl_E(ctrl_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
        .imm_ext_E(imm_ext_E), .pc_E(pc_E), .pcp4_E(pcp4_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .funct3_E(funct3_E), .funct7b5_E(funct7b5_E), .valid_E(valid_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign dut_e = '{ctrl_E, rd1_E, rd2_E, imm_ext_E, pc_E, pcp4_E, rs1_E, rs2_E, rd_E,
                     funct3_E, funct7b5_E, valid_E};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [15:0] c, input logic [31:0] d1, input logic [4:0] d);
        e_t din;
        @(negedge clk);
        rst = r; flush_E = f; stall_E = s; valid_D = v; ctrl_D = c; rd1_D = d1; rd_D = d;
        rd2_D = $urandom; imm_ext_D = $urandom; pc_D = $urandom; pcp4_D = $urandom;
        rs1_D = 5'($urandom); rs2_D = 5'($urandom); funct3_D = 3'($urandom);
        funct7b5_D = 1'($urandom);
        din = '{ctrl_D, rd1_D, rd2_D, imm_ext_D, pc_D, pcp4_D, rs1_D, rs2_D, rd_D,
                funct3_D, funct7b5_D, valid_D};
        @(posedge clk);
        #1;
        if (r) begin
            exp_e = '0; sc = 0; fc = 0;
        end else if (f) begin
            exp_e = '0; fc = (fc < CMAX) ? fc + 1 : CMAX;
        end else if (s) begin
            sc = (sc < CMAX) ? sc + 1 : CMAX;
        end else begin
            exp_e = din;
        end
        check("e_stage", 256'(dut_e), 256'(exp_e));
        check("stall_cnt", 256'(stall_cnt), 256'(sc));
        check("flush_cnt", 256'(flush_cnt), 256'(fc));
    endtask

    initial begin
        exp_e = '0; sc = 0; fc = 0;
        rst = 1'b1; stall_E = 1'b0; flush_E = 1'b0; valid_D = 1'b0; ctrl_D = '0;
        rd1_D = '0; rd2_D = '0; imm_ext_D = '0; pc_D = '0; pcp4_D = '0;
        rs1_D = '0; rs2_D = '0; rd_D = '0; funct3_D = '0; funct7b5_D = 1'b0;
        //         rst  fl   st   vD   ctrl      rd1            rd     xv   xctrl     xrd1           xrd   sc fc
        vt[0]  = '{1'b1,1'b0,1'b0,1'b1,16'hFFFF,32'hDEAD_BEEF,5'd31, 1'b0,16'h0000,32'h0000_0000,5'd0, 0, 0};
        vt[1]  = '{1'b1,1'b0,1'b0,1'b1,16'hFFFF,32'hDEAD_BEEF,5'd31, 1'b0,16'h0000,32'h0000_0000,5'd0, 0, 0};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b1,16'h8A59,32'h1234_5678,5'd7,  1'b1,16'h8A59,32'h1234_5678,5'd7, 0, 0};
        vt[3]  = '{1'b0,1'b0,1'b1,1'b1,16'h1111,32'hAAAA_0000,5'd3,  1'b1,16'h8A59,32'h1234_5678,5'd7, 1, 0};
        vt[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h2222,32'hBBBB_0000,5'd4,  1'b1,16'h8A59,32'h1234_5678,5'd7, 2, 0};
        vt[5]  = '{1'b0,1'b0,1'b1,1'b0,16'h3333,32'hCCCC_0000,5'd5,  1'b1,16'h8A59,32'h1234_5678,5'd7, 3, 0};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b1,16'h4444,32'hDDDD_0000,5'd9,  1'b1,16'h4444,32'hDDDD_0000,5'd9, 3, 0};
        vt[7]  = '{1'b0,1'b1,1'b1,1'b1,16'h0800,32'hEEEE_0000,5'd10, 1'b0,16'h0000,32'h0000_0000,5'd0, 3, 1};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b1,16'h0100,32'h0F0F_0F0F,5'd12, 1'b1,16'h0100,32'h0F0F_0F0F,5'd12,3, 1};
        vt[9]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0000_0000,5'd1,  1'b1,16'h0100,32'h0F0F_0F0F,5'd12,4, 1};
        vt[10] = '{1'b1,1'b0,1'b1,1'b1,16'h5555,32'h5555_5555,5'd2,  1'b0,16'h0000,32'h0000_0000,5'd0, 0, 0};
        vt[11] = '{1'b0,1'b0,1'b0,1'b1,16'h6666,32'h7777_7777,5'd13, 1'b1,16'h6666,32'h7777_7777,5'd13,0, 0};
        vt[12] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0000_0001,5'd0,  1'b0,16'h0000,32'h0000_0001,5'd0, 0, 0};
        vt[13] = '{1'b1,1'b1,1'b0,1'b1,16'hFFFF,32'hFFFF_FFFF,5'd31, 1'b0,16'h0000,32'h0000_0000,5'd0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            step(vt[i].rst, vt[i].flush, vt[i].stall, vt[i].valid, vt[i].ctrl, vt[i].rd1, vt[i].rd);
            check($sformatf("vec%0d_valid", i), 256'(valid_E), 256'(vt[i].x_valid));
            check($sformatf("vec%0d_ctrl", i), 256'(ctrl_E), 256'(vt[i].x_ctrl));
            check($sformatf("vec%0d_rd1", i), 256'(rd1_E), 256'(vt[i].x_rd1));
            check($sformatf("vec%0d_rd", i), 256'(rd_E), 256'(vt[i].x_rd));
            check($sformatf("vec%0d_scnt", i), 256'(stall_cnt), 256'(vt[i].x_sc));
            check($sformatf("vec%0d_fcnt", i), 256'(flush_cnt), 256'(vt[i].x_fc));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'(i % 2), 1'b1, 16'hFFFF, $urandom, 5'($urandom));
        check("flush_sat", 256'(flush_cnt), 256'(15));
        check("flush_sat_scnt", 256'(stall_cnt), 256'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 32'hCAFE_F00D, 5'd21);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'($urandom), $urandom, 5'($urandom));
        check("stall_sat", 256'(stall_cnt), 256'(15));
        check("stall_hold_rd1", 256'(rd1_E), 256'(32'hCAFE_F00D));
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 16'($urandom), $urandom, 5'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
